// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_prog family: address width,
// status-flag reset values and elaboration-time parameter legality.
package fifo_pkg;

  localparam logic EMPTY_RST = 1'b1;
  localparam logic FULL_RST  = 1'b0;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int af, input int ae);
    return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one read port. Read port is
// combinational when FWFT_EN is defined, registered (with hold) otherwise.
module sync_fifo_mem #(
  parameter int DATA_width = 8,
  parameter int DATA_depth = 32,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_width-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_width-1:0] rd_data
);

  logic [DATA_width-1:0] mem [DATA_depth];

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

`ifdef FWFT_EN
  logic unused_rd;
  assign unused_rd = rd_en ^ rst_n;
  assign rd_data   = mem[rd_addr];
`else
  // Write and read never target the same entry in one cycle: full blocks writes.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
`endif

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost thresholds,
// sticky overflow/underflow and synchronous flush. Define FWFT_EN for fall-through reads.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter  int DATA_width = 8,
  parameter  int DATA_depth = 32,
  parameter  int AF_LEVEL   = DATA_depth - 4,
  parameter  int AE_LEVEL   = 4,
  localparam int AW         = addr_w(DATA_depth)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_width-1:0] Data_in,
  input  logic                  rd_en,
  output logic [DATA_width-1:0] Data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
);

  if (!params_ok(DATA_width, DATA_depth, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_prog: illegal DATA_width/DATA_depth/AF_LEVEL/AE_LEVEL");
  end

  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic        wr_acc, rd_acc;

  assign wr_acc     = wr_en && !full  && !flush;
  assign rd_acc     = rd_en && !empty && !flush;
  assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_acc);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(rd_acc);
  // Wrap-bit pointer difference is the occupancy, 0..DATA_depth.
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || flush) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
      count        <= '0;
      full         <= FULL_RST;
      empty        <= EMPTY_RST;
      almost_full  <= FULL_RST;
      almost_empty <= EMPTY_RST;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= (count_nxt == (AW+1)'(DATA_depth));
      empty        <= (count_nxt == '0);
      almost_full  <= (int'(count_nxt) >= AF_LEVEL);
      almost_empty <= (int'(count_nxt) <= AE_LEVEL);
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end

  sync_fifo_mem #(
    .DATA_width (DATA_width),
    .DATA_depth (DATA_depth),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (Data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (Data_out)
  );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: stimulus pushes expected read data,
// a monitor pops and compares on every accepted read.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n, flush, wr_en, rd_en;
  logic [7:0] Data_in, Data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [5:0] count;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sync_fifo_prog dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .Data_in      (Data_in),
    .rd_en        (rd_en),
    .Data_out     (Data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Monitor: an accepted read must match the oldest expected word.
  always @(posedge clk) begin
    logic [7:0] got, want;
    if (rst_n && !flush && rd_en && !empty) begin
`ifdef FWFT_EN
      got = Data_out;
`else
      @(negedge clk);
      got = Data_out;
`endif
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: unexpected read got %02h required none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL rd_data: got %02h required %02h", got, want);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic chk_status(input int c);
    chk("count", 32'(count), 32'(c));
    chk("empty", 32'(empty), 32'(c == 0));
    chk("full", 32'(full), 32'(c == 32));
    chk("almost_full", 32'(almost_full), 32'(c >= 28));
    chk("almost_empty", 32'(almost_empty), 32'(c <= 4));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; Data_in = '0;
    #12;
    chk_status(0);
    chk("overflow_rst", 32'(overflow), 32'd0);
    chk("underflow_rst", 32'(underflow), 32'd0);
    chk("data_out_rst", 32'(Data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full with 0x01..0x20
    for (int i = 1; i <= 32; i++) begin
      wr_en = 1'b1; Data_in = 8'(i);
      tick();
      chk_status(i);
    end
    Data_in = 8'hFF;
    tick();
    chk("overflow_set", 32'(overflow), 32'd1);
    chk_status(32);
    wr_en = 1'b0;

    // Drain in order
    for (int i = 1; i <= 32; i++) begin
      rd_en = 1'b1; exp_q.push_back(8'(i));
      tick();
      chk_status(32 - i);
    end
    tick();
    chk("underflow_set", 32'(underflow), 32'd1);
    chk_status(0);
`ifndef FWFT_EN
    chk("data_out_hold", 32'(Data_out), 32'h20);
`endif
    rd_en = 1'b0;

    // Steady state at count 10 with simultaneous write/read
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1; Data_in = 8'(8'h40 + k);
      tick();
    end
    chk_status(10);
    for (int k = 0; k < 100; k++) begin
      wr_en = 1'b1; Data_in = 8'(8'h4A + k);
      rd_en = 1'b1; exp_q.push_back(8'(8'h40 + k));
      tick();
      chk("count_steady", 32'(count), 32'd10);
    end
    wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(8'(8'hA4 + k));
      tick();
    end
    rd_en = 1'b0;
    chk_status(5);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Flush beats a concurrent write
    flush = 1'b1; wr_en = 1'b1; Data_in = 8'hEE;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk_status(0);
    chk("overflow_flush", 32'(overflow), 32'd0);
    chk("underflow_flush", 32'(underflow), 32'd0);
`ifndef FWFT_EN
    chk("data_out_flush_hold", 32'(Data_out), 32'hA8);
`endif
    wr_en = 1'b1; Data_in = 8'h77;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; exp_q.push_back(8'h77);
    tick();
    rd_en = 1'b0;
    chk_status(0);

    // Async reset mid-burst at count 17
    for (int k = 0; k < 17; k++) begin
      wr_en = 1'b1; Data_in = 8'(8'h10 + k);
      tick();
    end
    chk_status(17);
    #3;
    rst_n = 1'b0;
    #1;
    chk_status(0);
    chk("overflow_arst", 32'(overflow), 32'd0);
    chk("underflow_arst", 32'(underflow), 32'd0);
`ifndef FWFT_EN
    chk("data_out_arst", 32'(Data_out), 32'd0);
`endif
    wr_en = 1'b0;
    #2;
    rst_n = 1'b1;
    wr_en = 1'b1; Data_in = 8'h99;
    tick();
    chk_status(1);
    wr_en = 1'b0; rd_en = 1'b1; exp_q.push_back(8'h99);
    tick();
    rd_en = 1'b0;
    chk_status(0);

`ifdef FWFT_EN
    wr_en = 1'b1; Data_in = 8'hA5;
    tick();
    chk("fwft_head", 32'(Data_out), 32'hA5);
    chk("fwft_empty", 32'(empty), 32'd0);
    Data_in = 8'h5A;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; exp_q.push_back(8'hA5);
    tick();
    rd_en = 1'b0;
    chk("fwft_next", 32'(Data_out), 32'h5A);
`endif

    tick();
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO: next generation of the team's FIFO buffering, for data paths where producer and consumer share one clock. Adds a fill-level count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. An optional first-word-fall-through read mode is selected at compile time.

## Interface
- DATA_width, 8: word width in bits, ≥1.
- DATA_depth, 32: number of entries; power of two, ≥4.
- AF_LEVEL, DATA_depth-4: almost_full asserts when count ≥ AF_LEVEL; range 1..DATA_depth.
- AE_LEVEL, 4: almost_empty asserts when count ≤ AE_LEVEL; range 0..DATA_depth-1.
- AW (local): $clog2(DATA_depth).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pointers, count, flags and errors.
- wr_en  in  1  write request.
- Data_in  in  DATA_width  write data.
- rd_en  in  1  read request; in FWFT mode, acknowledges the head word.
- Data_out  out  DATA_width  read data.
- full, empty  out  1  registered status.
- almost_full, almost_empty  out  1  registered threshold status.
- count  out  AW+1  current occupancy, 0..DATA_depth.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Reset values: Data_out 0, full 0, empty 1, almost_full 0, almost_empty 1, count 0, overflow 0, underflow 0, pointers 0. Memory is not cleared.
- Pointers: wr_ptr and rd_ptr are AW+1-bit binary. The low AW bits address memory; the MSB is the wrap bit. Both wrap naturally modulo 2·DATA_depth.
- Write is accepted iff wr_en && !full. Read is accepted iff rd_en && !empty.
- Full blocks writes even when a read is accepted in the same cycle.
- Both accepted in one cycle: both pointers advance and count is unchanged.
- count_next = count + wr_acc − rd_acc. count and all four status flags are registered from count_next:
  - full = (count_next == DATA_depth)
  - empty = (count_next == 0)
  - almost_full = (count_next ≥ AF_LEVEL)
  - almost_empty = (count_next ≤ AE_LEVEL)
- Errors:
  - wr_en while full sets overflow; the write is dropped.
  - rd_en while empty sets underflow; the read is dropped and Data_out holds.
  - Both flags stay set until flush or reset.
- flush has priority over wr_en/rd_en in the same cycle: both are ignored and no error is set. After flush, all outputs return to reset values except Data_out, which holds.
- Reset asserted mid-operation: immediate return to reset values. Stored data is lost logically.

## Timing
- Status flags and count change on the same edge that accepts the operation; there is no extra latency.
- First write at edge N: empty=0 and count=1 after edge N.
- Standard mode: read accepted at edge M gives Data_out = head word after edge M (1-cycle latency). Data_out holds between reads.
- A word written at edge N can be read by rd_en sampled at edge N+1 at the earliest.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- FWFT_EN defined:
  - Data_out continuously presents mem[rd_ptr] and is valid whenever empty=0.
  - rd_en pops; the next word appears after the same edge.
  - While empty=1, Data_out is undefined.
- FWFT_EN undefined: standard registered read as described under Timing.
- Counters, flags and errors are identical in both modes.

## Structure
- Package fifo_pkg holds:
  - the address-width helper function (clog2-based);
  - the reset constants for flags (EMPTY_RST=1, FULL_RST=0);
  - the parameter-legality checks (power-of-two depth, threshold ranges), evaluated at elaboration.
- Sub-module sync_fifo_mem: a DATA_depth × DATA_width array with one synchronous write port and one read port. The read port is combinational under FWFT_EN and registered otherwise.
- The top level holds the pointers, count, flags and error logic.

## Test plan
- Reset, then write 0x01..0x20 (32 words, depth 32): almost_full rises at count 28, full=1 after the 32nd write. A 33rd write sets overflow=1 and count stays 32.
- From full, read 32 words: data returns 0x01..0x20 in order, with Data_out 1 cycle after each rd_en (standard mode). almost_empty rises at count 4, empty=1 at the end. An extra read sets underflow=1.
- Simultaneous write/read at count=10 for 100 cycles: count stays 10, data ordering is preserved, and the pointers wrap at least 3 times.
- At count 5 with overflow=1, assert flush together with wr_en: after the edge, count=0, empty=1, overflow=0, and no write is stored.
- Assert rst_n=0 asynchronously mid-burst at count 17: all outputs reach reset values without a clock edge; after release, the first write yields count=1.
- Build with FWFT_EN and write 0xA5 then 0x5A: after the write edge, Data_out=0xA5 with empty=0; rd_en for one cycle gives Data_out=0x5A.
